// File: rtl/dmem_pkg.sv
// Shared encodings and constants for the dmem_bank data memory.
package dmem_pkg;

  localparam int WORD_W = 32;

  // Access size encodings carried on the 2-bit size input.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Reset preload: words 0..PRELOAD_WORDS-1 receive 10, 20, 30, ...
  localparam int PRELOAD_WORDS = 6;
  localparam int PRELOAD_STEP  = 10;

  function automatic logic [WORD_W-1:0] preload_val(input int idx);
    return WORD_W'((idx + 1) * PRELOAD_STEP);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and shifted data for stores,
// right-aligned and extended data for loads, plus alignment checking.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [1:0]        lane_i,
  input  logic [WORD_W-1:0] raw_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [3:0]        be_o,
  output logic [WORD_W-1:0] st_word_o,
  output logic [WORD_W-1:0] ld_word_o,
  output logic              misalign_o
);

  logic [WORD_W-1:0] raw_shifted;

  // Decode the access size into lane enables and the extended load value.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    be_o        = 4'b0000;
    ld_word_o   = '0;
    misalign_o  = 1'b0;
    raw_shifted = raw_i >> {lane_i, 3'b000};
    st_word_o   = wdata_i << {lane_i, 3'b000};
    case (size_i)
      SZ_BYTE: begin
        be_o      = 4'b0001 << lane_i;
        ld_word_o = uns_i ? {24'h0, raw_shifted[7:0]}
                          : {{24{raw_shifted[7]}}, raw_shifted[7:0]};
      end
      SZ_HALF: begin
        misalign_o = lane_i[0];
        be_o       = 4'b0011 << lane_i;
        ld_word_o  = uns_i ? {16'h0, raw_shifted[15:0]}
                           : {{16{raw_shifted[15]}}, raw_shifted[15:0]};
      end
      SZ_WORD: begin
        misalign_o = (lane_i != 2'b00);
        be_o       = 4'b1111;
        ld_word_o  = raw_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_bank.sv
// Single-port data memory bank with a fixed-latency request/response
// handshake, byte/half/word accesses and error reporting.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1,
  parameter bit PRELOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign_err,
  output logic              range_err
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e            state_q;
  logic [1:0]        cnt_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              misalign_q;
  logic              range_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] raw_word;
  logic [3:0]        be;
  logic [DATA_W-1:0] st_word;
  logic [DATA_W-1:0] ld_word;
  logic              misalign;
  logic              range_hit;
  logic              acc_err;
  logic [DATA_W-1:0] wr_word_d;

  assign idx       = addr_q[IDX_W+1:2];
  assign raw_word  = mem[idx];
  assign range_hit = |(addr_q >> (IDX_W + 2));
  assign acc_err   = misalign | range_hit;

  dmem_lane_align u_align (
    .size_i     (size_q),
    .uns_i      (uns_q),
    .lane_i     (addr_q[1:0]),
    .raw_i      (raw_word),
    .wdata_i    (wdata_q),
    .be_o       (be),
    .st_word_o  (st_word),
    .ld_word_o  (ld_word),
    .misalign_o (misalign)
  );

  // Merge the enabled store lanes into the current word; other lanes keep old data.
  always_comb begin
    wr_word_d = raw_word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) wr_word_d[8*k +: 8] = st_word[8*k +: 8];
    end
  end

  // Request FSM: capture on accept, count out the latency, present one response cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
      range_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q        <= we;
            size_q      <= size;
            uns_q       <= uns;
            addr_q      <= addr;
            wdata_q     <= wdata;
            cnt_q       <= 2'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            misalign_q  <= misalign;
            range_q     <= range_hit;
            rdata_q     <= (!we_q && !acc_err) ? ld_word : '0;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rdata_q     <= '0;
          misalign_q  <= 1'b0;
          range_q     <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Storage: reset preloads the low words, stores commit at the end of the response cycle.
  always_ff @(posedge clk) begin
    // NOTE: the array is not cleared on reset; only the preload words are written so it can map to RAM.
    if (rst) begin
      if (PRELOAD) begin
        for (int i = 0; i < PRELOAD_WORDS; i++) begin
          if (i < DEPTH) mem[IDX_W'(i)] <= preload_val(i);
        end
      end
    end else if (state_q == S_RESP && we_q && !acc_err) begin
      mem[idx] <= wr_word_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rdata        = rdata_q;
  assign misalign_err = misalign_q;
  assign range_err    = range_q;

endmodule

// File: tb/tb_dmem_bank.sv
// Directed bench for dmem_bank: a vector table on a LATENCY=1 instance plus
// hand-written reset and back-to-back spacing sequences (LATENCY=3 instance).
module tb_dmem_bank;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // LATENCY = 1 instance
  logic        req_valid, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        req_ready, rsp_valid, misalign_err, range_err;
  logic [31:0] rdata;

  // LATENCY = 3 instance
  logic        req_valid3, we3, uns3;
  logic [1:0]  size3;
  logic [31:0] addr3, wdata3;
  logic        req_ready3, rsp_valid3, misalign_err3, range_err3;
  logic [31:0] rdata3;

  dmem_bank #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(1), .PRELOAD(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .we(we), .size(size), .uns(uns), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rdata(rdata),
    .misalign_err(misalign_err), .range_err(range_err)
  );

  dmem_bank #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(3), .PRELOAD(1'b1)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .we(we3), .size(size3), .uns(uns3), .addr(addr3), .wdata(wdata3),
    .rsp_valid(rsp_valid3), .rdata(rdata3),
    .misalign_err(misalign_err3), .range_err(range_err3)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_rng;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] er, input logic em, input logic eg);
    vec_t v;
    v.we = w; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_mis = em; v.exp_rng = eg;
    vecs.push_back(v);
  endtask

  // One request on the LATENCY=1 instance; lat is the number of cycles from the
  // accepting cycle to the cycle with rsp_valid high (-1 if none arrived).
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic mis,
                        output logic rng, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd  = rdata;
    mis = misalign_err;
    rng = range_err;
    if (!rsp_valid) lat = -1;
    @(negedge clk);
    check("pulse_end_valid", {31'h0, rsp_valid}, 32'h0);
    check("pulse_end_rdata", rdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        mis, rng;
    int          lat;
    int          seen;
    int          acc[$];
    int          rsp[$];
    logic [31:0] rd3[$];

    rst = 1'b1;
    req_valid = 1'b0; we = 1'b0; uns = 1'b0; size = SZ_WORD; addr = '0; wdata = '0;
    req_valid3 = 1'b0; we3 = 1'b0; uns3 = 1'b0; size3 = SZ_WORD; addr3 = '0; wdata3 = '0;

    // Vector table, applied in order after reset (preload 10..60 in words 0..5).
    add(1'b0, SZ_WORD, 1'b0, 32'h008, 32'h0,        32'd30,       1'b0, 1'b0);
    add(1'b1, SZ_WORD, 1'b0, 32'h010, 32'hAABBCCDD, 32'h0,        1'b0, 1'b0);
    add(1'b0, SZ_BYTE, 1'b0, 32'h011, 32'h0,        32'hFFFFFFCC, 1'b0, 1'b0);
    add(1'b0, SZ_HALF, 1'b1, 32'h012, 32'h0,        32'h0000AABB, 1'b0, 1'b0);
    add(1'b0, SZ_HALF, 1'b0, 32'h012, 32'h0,        32'hFFFFAABB, 1'b0, 1'b0);
    add(1'b0, SZ_BYTE, 1'b1, 32'h013, 32'h0,        32'h000000AA, 1'b0, 1'b0);
    add(1'b1, SZ_BYTE, 1'b0, 32'h004, 32'h1234565A, 32'h0,        1'b0, 1'b0);
    add(1'b0, SZ_WORD, 1'b0, 32'h004, 32'h0,        32'h0000005A, 1'b0, 1'b0);
    add(1'b0, SZ_WORD, 1'b0, 32'h006, 32'h0,        32'h0,        1'b1, 1'b0);
    add(1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1);
    add(1'b0, SZ_WORD, 1'b0, 32'h000, 32'h0,        32'd10,       1'b0, 1'b0);
    add(1'b1, SZ_HALF, 1'b0, 32'h002, 32'h0000BEEF, 32'h0,        1'b0, 1'b0);
    add(1'b0, SZ_WORD, 1'b0, 32'h000, 32'h0,        32'hBEEF000A, 1'b0, 1'b0);
    add(1'b0, SZ_BYTE, 1'b0, 32'h003, 32'h0,        32'hFFFFFFBE, 1'b0, 1'b0);
    add(1'b0, SZ_RSVD, 1'b0, 32'h000, 32'h0,        32'h0,        1'b1, 1'b0);
    add(1'b1, SZ_HALF, 1'b0, 32'h001, 32'h00001111, 32'h0,        1'b1, 1'b0);
    add(1'b0, SZ_WORD, 1'b0, 32'h000, 32'h0,        32'hBEEF000A, 1'b0, 1'b0);
    add(1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0,        32'h0,        1'b1, 1'b1);
    add(1'b1, SZ_WORD, 1'b0, 32'h0FC, 32'h12345678, 32'h0,        1'b0, 1'b0);
    add(1'b0, SZ_WORD, 1'b0, 32'h0FC, 32'h0,        32'h12345678, 1'b0, 1'b0);
    add(1'b0, SZ_WORD, 1'b0, 32'h014, 32'h0,        32'd60,       1'b0, 1'b0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready",     {31'h0, req_ready},    32'h1);
    check("reset_rsp_valid", {31'h0, rsp_valid},    32'h0);
    check("reset_rdata",     rdata,                 32'h0);
    check("reset_misalign",  {31'h0, misalign_err}, 32'h0);
    check("reset_range",     {31'h0, range_err},    32'h0);
    check("reset_ready3",    {31'h0, req_ready3},   32'h1);

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, mis, rng, lat);
      check($sformatf("vec%0d_rdata", i),    rd,             vecs[i].exp_rdata);
      check($sformatf("vec%0d_misalign", i), {31'h0, mis},   {31'h0, vecs[i].exp_mis});
      check($sformatf("vec%0d_range", i),    {31'h0, rng},   {31'h0, vecs[i].exp_rng});
      check($sformatf("vec%0d_latency", i),  32'(lat),       32'd2);
    end

    // Reset during WAIT of a store to word 0: no response, preload value remains.
    @(negedge clk);
    req_valid = 1'b1; we = 1'b1; size = SZ_WORD; uns = 1'b0; addr = 32'h0; wdata = 32'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready_after_reset", {31'h0, req_ready}, 32'h1);
    seen = 0;
    repeat (4) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, rd, mis, rng, lat);
    check("abort_word0", rd, 32'd10);

    // Reset during WAIT of a store to a non-preloaded word: old contents survive.
    do_req(1'b1, SZ_WORD, 1'b0, 32'h018, 32'h00000077, rd, mis, rng, lat);
    @(negedge clk);
    req_valid = 1'b1; we = 1'b1; size = SZ_WORD; addr = 32'h018; wdata = 32'h0000BAD0;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, SZ_WORD, 1'b0, 32'h018, 32'h0, rd, mis, rng, lat);
    check("abort_word6", rd, 32'h00000077);

    // Request presented together with reset is dropped.
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1; we = 1'b0; size = SZ_WORD; addr = 32'h008;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    check("drop_ready", {31'h0, req_ready}, 32'h1);
    seen = 0;
    repeat (4) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    check("drop_no_rsp", 32'(seen), 32'd0);

    // LATENCY=3: hold req_valid high continuously and record accepts/responses.
    @(negedge clk);
    req_valid3 = 1'b1; we3 = 1'b0; size3 = SZ_WORD; uns3 = 1'b0; addr3 = 32'h008;
    for (int c = 0; c < 22; c++) begin
      if (req_ready3) acc.push_back(c);
      if (rsp_valid3) begin
        rsp.push_back(c);
        rd3.push_back(rdata3);
      end
      @(negedge clk);
    end
    req_valid3 = 1'b0;
    check("l3_accept_count_ok", {31'h0, (acc.size() >= 4)}, 32'h1);
    check("l3_rsp_count_ok",    {31'h0, (rsp.size() >= 3)}, 32'h1);
    if (acc.size() >= 4 && rsp.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("l3_spacing%0d", i), 32'(acc[i+1] - acc[i]), 32'd5);
        check($sformatf("l3_latency%0d", i), 32'(rsp[i] - acc[i]),   32'd4);
        check($sformatf("l3_rdata%0d", i),   rd3[i],                 32'd30);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_bank.md
DMEM_BANK -- requirements
Module: dmem_bank

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits; fixed at 32 in this generation, other values unsupported.
REQ-002 Parameter ADDR_W, default 32: byte-address width.
REQ-003 Parameter DEPTH, default 64: number of words; must be a power of two, 4..4096.
REQ-004 Parameter LATENCY, default 1: wait cycles between acceptance and response, 1..4.
REQ-005 Parameter PRELOAD, default 1: when 1, reset loads words 0..5 with 10,20,30,40,50,60.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block can accept a request this cycle.
REQ-010 we  input  1  1 = store, 0 = load.
REQ-011 size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-012 uns  input  1  load zero-extends when 1 and sign-extends when 0; ignored for word accesses and stores.
REQ-013 addr  input  ADDR_W  byte address.
REQ-014 wdata  input  DATA_W  store data, right-aligned.
REQ-015 rsp_valid  output  1  one-cycle completion pulse for both loads and stores.
REQ-016 rdata  output  DATA_W  load result, valid only while rsp_valid is high.
REQ-017 misalign_err  output  1  completing access was misaligned or used the reserved size.
REQ-018 range_err  output  1  completing access was outside DEPTH.

Function
REQ-019 The FSM SHALL have three states, IDLE, WAIT and RESP, with req_ready = 1 only in IDLE.
REQ-020 A request SHALL be accepted when req_valid && req_ready; on acceptance, we, size, uns, addr and wdata are captured and the state moves to WAIT with cnt = LATENCY-1.
REQ-021 In WAIT, cnt SHALL decrement each cycle, and the state moves to RESP on the cycle after cnt reaches 0.
REQ-022 In RESP, rsp_valid, rdata and the error flags SHALL be driven for exactly one cycle, then the state returns to IDLE.
REQ-023 Timing: rsp_valid SHALL assert LATENCY+1 cycles after the acceptance edge, and the minimum request spacing is LATENCY+2 cycles.
REQ-024 Addressing: word index = addr[log2(DEPTH)+1:2]; lane = addr[1:0]; byte order is little-endian, with byte k at bits 8k+7:8k.
REQ-025 range_err SHALL be set when any addr bit above log2(DEPTH)+1 is nonzero.
REQ-026 misalign_err SHALL be set when size = 11, when a half access has addr[0] = 1, or when a word access has addr[1:0] != 0.
REQ-027 A store SHALL commit in the RESP cycle, writing only the addressed lanes (byte: 1 lane, half: 2 lanes, word: 4 lanes) and leaving other lanes unchanged.
REQ-028 A load SHALL read in the RESP cycle, right-align the addressed lanes, and sign- or zero-extend the result per uns.
REQ-029 On any error, a store SHALL be suppressed (memory unchanged), a load SHALL return rdata = 0, and both flags may assert together.
REQ-030 rdata SHALL be 0 for store responses.
REQ-031 rsp_valid, rdata, misalign_err and range_err SHALL be 0 in every cycle that is not RESP.
REQ-032 req_valid while req_ready = 0 SHALL be ignored; no request is queued and the requester must hold the request.
REQ-033 A load to an address stored by the immediately preceding request SHALL return the newly stored value.

Reset
REQ-034 When rst = 1 at a clock edge, the FSM SHALL go to IDLE, cnt = 0, all outputs = 0, and req_ready SHALL read 1 in the following cycle.
REQ-035 With PRELOAD = 1, reset SHALL load words 0..5 with 10..60; all other words are unchanged, and with PRELOAD = 0 every word is unchanged.
REQ-036 Reset during WAIT or RESP SHALL abort the operation: no store commits and no rsp_valid is issued.
REQ-037 A request presented in the same cycle as rst SHALL be dropped.

Structure
REQ-038 Package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum and the preload constants.
REQ-039 One sub-module, dmem_lane_align, SHALL be combinational, taking size, uns, lane, a raw word and wdata, and producing the byte-write mask, the shifted store word, the extended load word and misalign_err.
REQ-040 Storage SHALL be a DEPTH x DATA_W register array written only in RESP and on reset preload.

Verification
REQ-041 Scenario: LATENCY = 1, after reset, load word at addr 0x8 -> rsp_valid exactly 2 cycles after acceptance, rdata = 30, no errors.
REQ-042 Scenario: store word 0xAABBCCDD to 0x10, then load byte 0x11 with uns = 0 -> 0xFFFFFFCC; then load half 0x12 with uns = 1 -> 0x0000AABB.
REQ-043 Scenario: store byte 0x5A to 0x4, then load word 0x4 -> 0x0000005A (word 1 held 20 = 0x14, so byte 0 replaced and the upper bytes stay 0).
REQ-044 Scenario: load word 0x6 -> misalign_err = 1, rdata = 0; store word to 0x100 with DEPTH = 64 -> range_err = 1 and a later readback of word 0 = 10.
REQ-045 Scenario: LATENCY = 3, hold req_valid high continuously -> accepts spaced 5 cycles apart and req_ready low for 4 cycles after each accept.
REQ-046 Scenario: assert rst during WAIT of a store of 0x1234 to 0x0 -> no rsp_valid, and word 0 reads 10 afterwards.
